if_loader_ctrl: RTL and testbench

- Sequencing controller for the instruction-fetch stage.
- Receives a byte stream from the debug UART receiver and assembles it into 32-bit words.
- Writes the words into instruction memory through the fetch stage's write port (address, instruction, write flag).
- After loading, gates pipeline advance through the step enable: free-run until halt, or single-step on command.

---
 rtl/if_loader_ctrl.sv | 169 ++++++++++++++++
 tb/tb_if_loader_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_loader_ctrl.sv
// Instruction-fetch loader/sequencer: assembles UART bytes into words, writes them to
// instruction memory, then gates pipeline advance. Optional cycle counter: IF_LOADER_CYCLE_COUNT_EN.
module if_loader_ctrl #(
  parameter int          BITS_SIZE  = 32,
  parameter int          SIZE_TOTAL = 256,
  parameter logic [7:0]  CMD_LOAD   = 8'h4C,
  parameter logic [7:0]  CMD_RUN    = 8'h43,
  parameter logic [7:0]  CMD_STEP   = 8'h53,
  parameter logic [7:0]  CMD_NEXT   = 8'h4E
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_halt,
  output logic                 o_step,
  output logic [BITS_SIZE-1:0] o_instruction_address,
  output logic [BITS_SIZE-1:0] o_instruction,
  output logic                 o_flag_write_intruc,
  output logic [2:0]           o_state,
  output logic [6:0]           o_words_loaded
`ifdef IF_LOADER_CYCLE_COUNT_EN
  ,
  output logic [BITS_SIZE-1:0] o_cycle_count
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READY = 3'd3,
    ST_RUN   = 3'd4,
    ST_STEP  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam logic [6:0] LAST_WORD = 7'(SIZE_TOTAL / 4 - 1);

  state_t                 state_q, state_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [23:0]            shift_q, shift_d;
  logic [BITS_SIZE-1:0]   instr_q, instr_d;
  logic [BITS_SIZE-1:0]   addr_q, addr_d;
  logic                   wr_q, wr_d;
  logic [6:0]             words_q, words_d;
  logic                   step_q, step_d;
  logic                   load_start;

  // Handshake: a byte is consumed only in the cycle i_rx_done=1; there is no back-pressure,
  // so every state must decide that same cycle whether the byte is used or dropped.
  wire is_load = i_rx_done && (i_rx_data == CMD_LOAD);
  wire is_run  = i_rx_done && (i_rx_data == CMD_RUN);
  wire is_step = i_rx_done && (i_rx_data == CMD_STEP);
  wire is_next = i_rx_done && (i_rx_data == CMD_NEXT);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (is_load) state_d = ST_LOAD;
      ST_LOAD:  if (i_rx_done && byte_cnt_q == 2'd3) state_d = ST_WRITE;
      ST_WRITE: begin
        if (instr_q == '1 || words_q == LAST_WORD) state_d = ST_READY;
        else                                       state_d = ST_LOAD;
      end
      ST_READY, ST_DONE: begin
        if (is_load)      state_d = ST_LOAD;
        else if (is_run)  state_d = ST_RUN;
        else if (is_step) state_d = ST_STEP;
      end
      ST_RUN, ST_STEP: if (i_halt) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; every output leaves from a register
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    instr_d    = instr_q;
    addr_d     = addr_q;
    wr_d       = 1'b0;
    words_d    = words_q;
    load_start = (state_q == ST_IDLE || state_q == ST_READY || state_q == ST_DONE)
                 && state_d == ST_LOAD;
    if (load_start) begin
      byte_cnt_d = 2'd0;
      words_d    = 7'd0;
      addr_d     = '0;
    end
    case (state_q)
      ST_LOAD: begin
        if (i_rx_done) begin
          shift_d    = {shift_q[15:0], i_rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wr_d    = 1'b1;
            instr_d = BITS_SIZE'({shift_q, i_rx_data});
            addr_d  = BITS_SIZE'({words_q, 2'b00});
          end
        end
      end
      ST_WRITE: begin
        words_d = words_q + 7'd1;
        // A byte landing during the write strobe starts the next word
        if (state_d == ST_LOAD && i_rx_done) begin
          shift_d    = {shift_q[15:0], i_rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end
      default: ;
    endcase
    step_d = (state_d == ST_RUN) || (state_q == ST_STEP && is_next && !i_halt);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      byte_cnt_q <= 2'd0;
      shift_q    <= '0;
      instr_q    <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      words_q    <= 7'd0;
      step_q     <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      instr_q    <= instr_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      words_q    <= words_d;
      step_q     <= step_d;
    end
  end

`ifdef IF_LOADER_CYCLE_COUNT_EN
  logic [BITS_SIZE-1:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (load_start)
      cyc_cnt_d = '0;
    else if (step_q && state_q != ST_DONE && cyc_cnt_q != '1)
      cyc_cnt_d = cyc_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) cyc_cnt_q <= '0;
    else          cyc_cnt_q <= cyc_cnt_d;
  end

  assign o_cycle_count = cyc_cnt_q;
`endif

  assign o_step                = step_q;
  assign o_instruction_address = addr_q;
  assign o_instruction         = instr_q;
  assign o_flag_write_intruc   = wr_q;
  assign o_state               = state_q;
  assign o_words_loaded        = words_q;

endmodule

// File: tb/tb_if_loader_ctrl.sv
// Bench for if_loader_ctrl: random byte streams against a stream-level reference model,
// write strobes and step pulses checked by a scoreboard monitor.
module tb_if_loader_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        halt;
  logic        o_step;
  logic [31:0] o_addr;
  logic [31:0] o_instr;
  logic        o_wr;
  logic [2:0]  o_state;
  logic [6:0]  o_words;
`ifdef IF_LOADER_CYCLE_COUNT_EN
  logic [31:0] o_cycle_count;
`endif

  if_loader_ctrl dut (
    .i_clk                 (clk),
    .i_reset               (rst_n),
    .i_rx_data             (rx_data),
    .i_rx_done             (rx_done),
    .i_halt                (halt),
    .o_step                (o_step),
    .o_instruction_address (o_addr),
    .o_instruction         (o_instr),
    .o_flag_write_intruc   (o_wr),
    .o_state               (o_state),
    .o_words_loaded        (o_words)
`ifdef IF_LOADER_CYCLE_COUNT_EN
    ,
    .o_cycle_count         (o_cycle_count)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  int          exp_step_q[$];

  // Reference model at byte-stream level
  typedef enum {M_IDLE, M_LOAD, M_READY, M_RUN, M_STEP, M_DONE} mode_t;
  mode_t       m_mode;
  int          m_nbytes;
  int          m_words;
  logic [31:0] m_part;
  int          run_len;

  function automatic logic [2:0] mode_code(mode_t m);
    case (m)
      M_IDLE:  return 3'd0;
      M_LOAD:  return 3'd1;
      M_READY: return 3'd3;
      M_RUN:   return 3'd4;
      M_STEP:  return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_nbytes = 0; m_words = 0; m_part = '0;
    exp_q.delete();
    exp_step_q.delete();
  endtask

  task automatic model_start_load();
    m_mode = M_LOAD; m_nbytes = 0; m_words = 0;
  endtask

  // stamp: cycle index at which a step pulse caused by this byte must be seen
  task automatic model_byte(input logic [7:0] b, input int stamp);
    case (m_mode)
      M_IDLE: if (b == 8'h4C) model_start_load();
      M_LOAD: begin
        m_part = {m_part[23:0], b};
        m_nbytes++;
        if (m_nbytes == 4) begin
          exp_q.push_back({32'(m_words * 4), m_part});
          m_words++;
          m_nbytes = 0;
          if (m_part == 32'hFFFF_FFFF || m_words == 64) m_mode = M_READY;
        end
      end
      M_READY, M_DONE: begin
        if (b == 8'h4C) model_start_load();
        else if (b == 8'h43) begin
          m_mode = M_RUN;
          for (int i = 0; i < run_len; i++) exp_step_q.push_back(stamp + i);
        end else if (b == 8'h53) m_mode = M_STEP;
      end
      M_STEP: if (b == 8'h4E) exp_step_q.push_back(stamp);
      default: ;
    endcase
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (o_wr) begin
      if (exp_q.size() == 0) check("unexpected_write", {o_addr, o_instr}, 64'hX);
      else check("write_addr_data", {o_addr, o_instr}, exp_q.pop_front());
    end
    if (o_step) begin
      if (exp_step_q.size() == 0) check("unexpected_step", 64'(cyc), 64'hX);
      else check("step_cycle", 64'(cyc), 64'(exp_step_q.pop_front()));
    end
  end

  // Driver tasks: each starts and ends at a falling edge
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1;
    model_byte(b, cyc + 1);
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_halt(input bit with_byte, input logic [7:0] b);
    halt = 1'b1;
    if (with_byte) begin rx_data = b; rx_done = 1'b1; end
    if (m_mode == M_RUN || m_mode == M_STEP) m_mode = M_DONE;
    else if (with_byte) model_byte(b, cyc + 1);
    @(negedge clk);
    halt = 1'b0; rx_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
      idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic do_run(input int h, input bit collide);
    int start;
    run_len = h;
    send_byte(8'h43);
    start = cyc;
    while (cyc < start + h - 1) @(negedge clk);
    send_halt(collide, 8'h4E);
    run_len = 0;
    idle(2);
  endtask

  task automatic do_step(input int n, input int max_gap, input bit collide);
    send_byte(8'h53);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, max_gap));
      send_byte(8'h4E);
    end
    idle(2);
    send_halt(collide, 8'h4E);
    idle(2);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, 64'(o_state), 64'(mode_code(m_mode)));
    check({tag, "_words"}, 64'(o_words), 64'(m_words));
    check({tag, "_step"},  64'(o_step),  64'd0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom();
    if (w == 32'hFFFF_FFFF) w = 32'h0;
    return w;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; halt = 1'b0; run_len = 0;
    model_reset();
    @(negedge clk);
    do_reset();
    check("rst_state", 64'(o_state), 64'd0);
    check("rst_step",  64'(o_step),  64'd0);
    check("rst_wr",    64'(o_wr),    64'd0);
    check("rst_addr",  64'(o_addr),  64'd0);
    check("rst_instr", 64'(o_instr), 64'd0);
    check("rst_words", 64'(o_words), 64'd0);

    // Directed load: one word then the halt opcode
    send_byte(8'h4C);
    send_word(32'h1234_5678, 0);
    send_word(32'hFFFF_FFFF, 0);
    idle(3);
    check("load_words", 64'(o_words), 64'd2);
    check("load_state", 64'(o_state), 64'd3);

    // Run for ten cycles then halt
    do_run(10, 1'b0);
    check_idle_outputs("run");
    check("run_done", 64'(o_state), 64'd6);

    // Step mode: three NEXTs five cycles apart
    send_byte(8'h53);
    for (int i = 0; i < 3; i++) begin
      idle(4);
      send_byte(8'h4E);
    end
    idle(3);
    send_halt(1'b0, 8'h00);
    idle(2);
    check_idle_outputs("step");

    // Reset in the middle of a word
    send_byte(8'h4C);
    send_byte(8'hAB);
    send_byte(8'hCD);
    do_reset();
    check("midrst_state", 64'(o_state), 64'd0);
    check("midrst_addr",  64'(o_addr),  64'd0);
    check("midrst_instr", 64'(o_instr), 64'd0);
    check("midrst_words", 64'(o_words), 64'd0);
    check("midrst_wr",    64'(o_wr),    64'd0);
    send_byte(8'h4C);
    send_word(rand_word(), 1);
    idle(3);
    check_idle_outputs("after_rst");

    // Overflow: 64 words then junk bytes
    do_reset();
    send_byte(8'h4C);
    for (int i = 0; i < 64; i++) send_word(rand_word(), 2);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 8'h3F)));
    idle(3);
    check_idle_outputs("overflow");

    // Halt colliding with a NEXT byte, in RUN and in STEP
    do_run($urandom_range(3, 12), 1'b1);
    check_idle_outputs("collide_run");
    do_step(2, 3, 1'b1);
    check_idle_outputs("collide_step");

    // Randomized load / run / step rounds
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(0, 5);
      send_byte(8'h4C);
      for (int i = 0; i < n; i++) send_word(rand_word(), 2);
      send_word(32'hFFFF_FFFF, 2);
      idle(2);
      for (int j = 0; j < 2; j++) send_byte(8'($urandom_range(0, 8'h3F)));
      idle(1);
      check_idle_outputs("rnd_load");
      if ($urandom_range(0, 1) == 1) do_run($urandom_range(1, 20), 1'($urandom_range(0, 1)));
      else do_step($urandom_range(1, 6), 5, 1'($urandom_range(0, 1)));
      check_idle_outputs("rnd_exec");
    end

    idle(4);
    check("write_queue_empty", 64'(exp_q.size()), 64'd0);
    check("step_queue_empty",  64'(exp_step_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
